// File: rtl/fpu_issue_q.sv
// FIFO issue queue and trig/okay sequencer in front of the fpu execution unit.
// Optional NaN-boxing of single-precision operands and results: define FPU_NANBOX_EN.
module fpu_issue_q #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned MDU_OP_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [MDU_OP_LEN-1:0] req_op,
    input  logic                  req_len_64,
    input  logic [63:0]           req_src1,
    input  logic [63:0]           req_src2,
    input  logic [4:0]            req_rd,
    output logic                  fpu_trig,
    output logic                  fpu_len_64,
    output logic [MDU_OP_LEN-1:0] fpu_op,
    output logic [63:0]           fpu_src1,
    output logic [63:0]           fpu_src2,
    output logic                  fpu_flush,
    input  logic [63:0]           fpu_out,
    input  logic                  fpu_okay,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [63:0]           rsp_data,
    output logic [4:0]            rsp_rd
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state, state_nxt;
    logic [MDU_OP_LEN-1:0] op_q   [DEPTH];
    logic                  len_q  [DEPTH];
    logic [63:0]           src1_q [DEPTH];
    logic [63:0]           src2_q [DEPTH];
    logic [4:0]            rd_q   [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic                  push, pop;
    logic                  head_len;
    logic [63:0]           head_src1, head_src2, result;

    assign req_ready = (count < COUNT_FULL);
    assign push      = req_valid && req_ready && !flush;
    assign pop       = (state == BUSY) && fpu_okay && !flush;

    assign head_len  = len_q[rd_ptr];
    assign head_src1 = src1_q[rd_ptr];
    assign head_src2 = src2_q[rd_ptr];
    assign fpu_len_64 = head_len;
    assign fpu_op     = op_q[rd_ptr];

`ifdef FPU_NANBOX_EN
    // Improperly boxed singles become the canonical single-precision NaN.
    always_comb begin
        fpu_src1 = head_src1;
        fpu_src2 = head_src2;
        result   = fpu_out;
        if (!head_len) begin
            if (head_src1[63:32] != '1) fpu_src1 = 64'hFFFF_FFFF_7FC0_0000;
            if (head_src2[63:32] != '1) fpu_src2 = 64'hFFFF_FFFF_7FC0_0000;
            result = {32'hFFFF_FFFF, fpu_out[31:0]};
        end
    end
`else
    always_comb begin
        fpu_src1 = head_src1;
        fpu_src2 = head_src2;
        result   = fpu_out;
    end
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            op_q[wr_ptr]   <= req_op;
            len_q[wr_ptr]  <= req_len_64;
            src1_q[wr_ptr] <= req_src1;
            src2_q[wr_ptr] <= req_src2;
            rd_q[wr_ptr]   <= req_rd;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_data <= '0;
            rsp_rd   <= '0;
        end else if (pop) begin
            rsp_data <= result;
            rsp_rd   <= rd_q[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fpu_trig  = 1'b0;
        fpu_flush = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0 && !flush) begin
                    fpu_trig  = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (fpu_okay) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Flush overrides every transition; only an in-flight op needs the unit killed.
        if (flush) begin
            state_nxt = IDLE;
            fpu_flush = (state == BUSY);
        end
    end
endmodule

// File: doc/fpu_issue_q.md
# fpu_issue_q

Issue queue and sequencer in front of the `fpu` execution unit. Buffers floating-point requests from the execute stage in a small FIFO and issues them one at a time with a single-cycle `trig`. It holds operands stable until `okay`, then presents the captured result to writeback on a valid/ready handshake. Pipeline flushes are applied to both the queue and the in-flight operation.

## Interface
Parameters:
- `DEPTH`, 2: FIFO entries; power of two, ≥2.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: asynchronous active-low reset.
- `flush` in 1: pipeline flush; kills queued, in-flight and pending-response work.
- `req_valid` in 1: request offered.
- `req_ready` out 1: `count < DEPTH`. Registered state only; does not depend on same-cycle pop.
- `req_op` in `MDU_OP_LEN`: operation code, passed unmodified to the unit.
- `req_len_64` in 1: 1 = double, 0 = single.
- `req_src1`, `req_src2` in 64: operands.
- `req_rd` in 5: destination tag, returned with the result.
- `fpu_trig` out 1: one-cycle start pulse.
- `fpu_len_64`, `fpu_op`, `fpu_src1`, `fpu_src2` out: head-entry fields.
- `fpu_flush` out 1: kill to the unit.
- `fpu_out` in 64: unit result.
- `fpu_okay` in 1: unit done.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: writeback accepts.
- `rsp_data` out 64: result.
- `rsp_rd` out 5: tag.

## Operation
- FIFO: write on `req_valid && req_ready && !flush`; pop on the `BUSY` completion. Pointers wrap modulo `DEPTH`. Write and pop in the same cycle are both honoured; `count` is unchanged.
- FSM has three states: `IDLE`, `BUSY`, `RESP`.
- `IDLE`:
  - `fpu_trig = (count != 0) && !flush`, combinational.
  - On trig, go to `BUSY`.
- `BUSY`:
  - Head entry drives `fpu_*` and stays stable.
  - On `fpu_okay`: capture `fpu_out` and the head `rd` into the result registers, pop, go to `RESP`.
- `RESP`:
  - `rsp_valid = 1`; data/tag held stable until `rsp_ready`.
  - On `rsp_ready`: go to `IDLE`.
  - The next trig can occur no earlier than the following cycle.
- Flush, any state, has priority over all other events:
  - FIFO emptied (count → 0); the same-cycle request is dropped.
  - State → `IDLE`.
  - `fpu_flush = 1` for that cycle iff state is `BUSY`.
  - `rsp_valid` drops the next cycle.
  - Flush coincident with `fpu_okay`: the result is discarded.
  - Flush coincident with `rsp_ready` in `RESP`: the response counts as delivered.
- `fpu_okay` outside `BUSY` is ignored.
- `fpu_flush` is 0 except as stated above.

## Timing
- Reset values:
  - `fpu_trig`, `fpu_flush`, `rsp_valid` = 0.
  - `rsp_data` = 0; `rsp_rd` = 0.
  - `req_ready` = 1.
  - State `IDLE`; count 0.
  - `fpu_*` operand outputs reflect entry 0, which is don't-care while trig = 0.
- Request accepted at cycle N into an empty, idle queue:
  - `fpu_trig` at N+1.
  - `fpu_okay` at M (M ≥ N+2) gives `rsp_valid` at M+1.
- Back-to-back: the next trig is at earliest 1 cycle after the response handshake.
- Reset assertion mid-operation: all state is cleared asynchronously. No `fpu_flush` is generated; the unit shares `rstn`.

## Configuration
- Macro: `FPU_NANBOX_EN`.
- Defined:
  - Single-precision operands (`len_64 = 0`) whose bits [63:32] are not all ones are replaced, as seen by the unit, by `0xFFFFFFFF_7FC00000`.
  - Single-precision results are forced to `{32'hFFFFFFFF, fpu_out[31:0]}` at capture.
- Undefined: operands and results pass through unmodified.

## Test plan
- Single op: `len_64=1`, src1 `0x3FF0000000000000`, src2 `0x4000000000000000`; unit model returns `0x4008000000000000` with okay 3 cycles after trig, `rsp_ready=1` → trig at N+1, `rsp_valid` at trig+4 with data `0x4008000000000000`, rd echoed.
- Fill: `DEPTH=2`, 3 requests back-to-back while the first is in `BUSY` → `req_ready=0` once 2 entries are held. All three complete in order, each with exactly one trig pulse.
- Backpressure: `rsp_ready=0` for 5 cycles → `rsp_valid`, data and rd stable. No new trig until after the handshake.
- Flush while `BUSY` with 1 entry queued → `fpu_flush` pulses for 1 cycle, no response, count 0, `req_ready=1`. A later request completes normally.
- Flush in the same cycle as `fpu_okay` → no `rsp_valid`; next state `IDLE`.
- `FPU_NANBOX_EN`: single op with src1 `0x00000000_3F800000` → unit sees `0xFFFFFFFF_7FC00000`. Unit result `0x0000000040400000` → `rsp_data` `0xFFFFFFFF40400000`. With the macro undefined, both values pass unmodified.
